// File: rtl/eth_port_stats.sv
// Purpose: passive per-channel AXI-Stream statistics (pkt/err/bcast/byte counters) with a snapshot bank and sticky overflow flags.
// Latency: an accepted beat reaches the live counters and ovf one cycle later; rd_en -> rd_data/rd_valid one cycle later.
// Backpressure: none; taps accepted beats only and never drives the stream.
//
// Ports:
//   axis_aclk, axis_aresetn         clock, asynchronous active-low reset
//   mon_tdata/tkeep/tvalid/tready/tlast/terr
//                                   tapped stream of each channel, channel c in slice c
//   cnt_clr[c]                      zeroes the live counters and ovf of channel c
//   snap_req                        copies all live counters into the snapshot bank
//   rd_en, rd_ch, rd_sel            snapshot read (sel 0 pkt, 1 err, 2 bcast, 3 byte)
//   rd_data, rd_valid               read result, valid pulses one cycle per rd_en
//   ovf[c]                          sticky overflow flag of channel c
module eth_port_stats #(
   parameter int NUM_CH   = 4,
   parameter int DATA_W   = 64,
   parameter int CNT_W    = 32,
   parameter int SATURATE = 1,
   localparam int KEEP_W  = DATA_W / 8,
   localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     axis_aclk,
   input  logic                     axis_aresetn,
   input  logic [NUM_CH*DATA_W-1:0] mon_tdata,
   input  logic [NUM_CH*KEEP_W-1:0] mon_tkeep,
   input  logic [NUM_CH-1:0]        mon_tvalid,
   input  logic [NUM_CH-1:0]        mon_tready,
   input  logic [NUM_CH-1:0]        mon_tlast,
   input  logic [NUM_CH-1:0]        mon_terr,
   input  logic [NUM_CH-1:0]        cnt_clr,
   input  logic                     snap_req,
   input  logic                     rd_en,
   input  logic [CH_W-1:0]          rd_ch,
   input  logic [1:0]               rd_sel,
   output logic [CNT_W-1:0]         rd_data,
   output logic                     rd_valid,
   output logic [NUM_CH-1:0]        ovf
);

   // Counter slots within a channel.
   localparam int PKT   = 0;
   localparam int ERR   = 1;
   localparam int BCAST = 2;
   localparam int BYTES = 3;

   typedef enum logic {SOP = 1'b0, MID = 1'b1} trk_t;

   trk_t             trk        [NUM_CH];
   logic [NUM_CH-1:0] bcast_flag;
   logic [CNT_W-1:0] live       [NUM_CH][4];
   logic [CNT_W-1:0] snap       [NUM_CH][4];

   logic [NUM_CH-1:0] acc;
   logic [NUM_CH-1:0] sop_hit;
   logic [NUM_CH-1:0] bcast_now;
   logic [NUM_CH-1:0] carry;
   logic [CNT_W:0]    inc        [NUM_CH][4];
   logic [CNT_W:0]    sum        [NUM_CH][4];
   logic [CNT_W-1:0]  nxt        [NUM_CH][4];
   logic [CNT_W-1:0]  rd_mux;
   logic [31:0]       rd_ch_ext;

   // Only the destination MAC of tdata is inspected; the rest is tapped but unused.
   logic unused_tdata;
   assign unused_tdata = ^mon_tdata;

   assign rd_ch_ext = 32'(rd_ch);

   // Increment amounts and next live values (one extra bit catches the carry).
   always_comb begin
      acc       = '0;
      sop_hit   = '0;
      bcast_now = '0;
      carry     = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         acc[c]     = mon_tvalid[c] & mon_tready[c];
         sop_hit[c] = (mon_tdata[c*DATA_W +: 48] == 48'hFFFF_FFFF_FFFF) &&
                      (mon_tkeep[c*KEEP_W +: 6] == 6'h3F);
         // Single-beat frames have no stored flag yet, so use the live match at SOP.
         bcast_now[c] = (trk[c] == SOP) ? sop_hit[c] : bcast_flag[c];

         inc[c][PKT]   = (CNT_W+1)'(acc[c] & mon_tlast[c]);
         inc[c][ERR]   = (CNT_W+1)'(acc[c] & mon_tlast[c] & mon_terr[c]);
         inc[c][BCAST] = (CNT_W+1)'(acc[c] & mon_tlast[c] & bcast_now[c]);
         inc[c][BYTES] = '0;
         for (int k = 0; k < KEEP_W; k++) begin
            if (acc[c] && mon_tkeep[c*KEEP_W + k])
               inc[c][BYTES] = inc[c][BYTES] + (CNT_W+1)'(1);
         end

         for (int k = 0; k < 4; k++) begin
            sum[c][k] = {1'b0, live[c][k]} + inc[c][k];
            if (sum[c][k][CNT_W]) begin
               carry[c]  = 1'b1;
               nxt[c][k] = (SATURATE != 0) ? {CNT_W{1'b1}} : sum[c][k][CNT_W-1:0];
            end else begin
               nxt[c][k] = sum[c][k][CNT_W-1:0];
            end
         end
      end
   end

   // Out-of-range channels fall through to zero.
   always_comb begin
      rd_mux = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (rd_ch_ext == 32'(c))
            rd_mux = snap[c][rd_sel];
      end
   end

   always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
      if (!axis_aresetn) begin
         bcast_flag <= '0;
         ovf        <= '0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            trk[c] <= SOP;
            for (int k = 0; k < 4; k++) begin
               live[c][k] <= '0;
               snap[c][k] <= '0;
            end
         end
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            // Frame tracker; cnt_clr deliberately leaves it alone.
            if (acc[c]) begin
               case (trk[c])
                  SOP: begin
                     if (mon_tlast[c]) begin
                        bcast_flag[c] <= 1'b0;
                     end else begin
                        trk[c]        <= MID;
                        bcast_flag[c] <= sop_hit[c];
                     end
                  end
                  MID: begin
                     if (mon_tlast[c]) begin
                        trk[c]        <= SOP;
                        bcast_flag[c] <= 1'b0;
                     end
                  end
                  default: trk[c] <= SOP;
               endcase
            end

            // Clear beats a same-cycle increment; that event is dropped.
            if (cnt_clr[c]) begin
               ovf[c] <= 1'b0;
               for (int k = 0; k < 4; k++)
                  live[c][k] <= '0;
            end else begin
               if (carry[c])
                  ovf[c] <= 1'b1;
               for (int k = 0; k < 4; k++)
                  live[c][k] <= nxt[c][k];
            end

            // Snapshot captures pre-update values of this cycle.
            if (snap_req) begin
               for (int k = 0; k < 4; k++)
                  snap[c][k] <= live[c][k];
            end
         end

         rd_valid <= rd_en;
         if (rd_en)
            rd_data <= rd_mux;
      end
   end

endmodule

// File: tb/tb_eth_port_stats.sv
module tb_eth_port_stats;

   localparam int NCH = 4;
   localparam int DW  = 64;
   localparam int KW  = 8;
   localparam int CW  = 16;

   localparam logic [63:0] D_BC = 64'h0000_FFFF_FFFF_FFFF;
   localparam logic [63:0] D_UC = 64'h0123_4567_89AB_CDEF;

   logic                 clk = 1'b0;
   logic                 axis_aresetn = 1'b0;
   logic [NCH*DW-1:0]    mon_tdata  = '0;
   logic [NCH*KW-1:0]    mon_tkeep  = '0;
   logic [NCH-1:0]       mon_tvalid = '0;
   logic [NCH-1:0]       mon_tready = '0;
   logic [NCH-1:0]       mon_tlast  = '0;
   logic [NCH-1:0]       mon_terr   = '0;
   logic [NCH-1:0]       cnt_clr    = '0;
   logic                 snap_req   = 1'b0;
   logic                 rd_en      = 1'b0;
   logic [1:0]           rd_ch      = '0;
   logic [1:0]           rd_sel     = '0;

   logic [CW-1:0]        rd_data_s, rd_data_w;
   logic                 rd_valid_s, rd_valid_w;
   logic [NCH-1:0]       ovf_s, ovf_w;

   int total = 0;
   int bad   = 0;

   // Expected read results, pushed when a read is issued, popped on rd_valid.
   logic [CW-1:0] q_s[$];
   logic [CW-1:0] q_w[$];
   string         t_s[$];
   string         t_w[$];

   always #5 clk = ~clk;

   eth_port_stats #(.NUM_CH(NCH), .DATA_W(DW), .CNT_W(CW), .SATURATE(1)) dut_s (
      .axis_aclk(clk), .axis_aresetn(axis_aresetn),
      .mon_tdata(mon_tdata), .mon_tkeep(mon_tkeep), .mon_tvalid(mon_tvalid),
      .mon_tready(mon_tready), .mon_tlast(mon_tlast), .mon_terr(mon_terr),
      .cnt_clr(cnt_clr), .snap_req(snap_req), .rd_en(rd_en), .rd_ch(rd_ch),
      .rd_sel(rd_sel), .rd_data(rd_data_s), .rd_valid(rd_valid_s), .ovf(ovf_s));

   eth_port_stats #(.NUM_CH(NCH), .DATA_W(DW), .CNT_W(CW), .SATURATE(0)) dut_w (
      .axis_aclk(clk), .axis_aresetn(axis_aresetn),
      .mon_tdata(mon_tdata), .mon_tkeep(mon_tkeep), .mon_tvalid(mon_tvalid),
      .mon_tready(mon_tready), .mon_tlast(mon_tlast), .mon_terr(mon_terr),
      .cnt_clr(cnt_clr), .snap_req(snap_req), .rd_en(rd_en), .rd_ch(rd_ch),
      .rd_sel(rd_sel), .rd_data(rd_data_w), .rd_valid(rd_valid_w), .ovf(ovf_w));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Read-result scoreboard, sampled on the falling edge.
   always @(negedge clk) begin
      if (rd_valid_s === 1'b1) begin
         total++;
         assert (q_s.size() != 0) else begin
            bad++;
            $error("FAIL spurious_rd_s: got rd_valid=1 expected no read pending");
         end
         if (q_s.size() != 0) chk(t_s.pop_front(), 32'(rd_data_s), 32'(q_s.pop_front()));
      end
      if (rd_valid_w === 1'b1) begin
         total++;
         assert (q_w.size() != 0) else begin
            bad++;
            $error("FAIL spurious_rd_w: got rd_valid=1 expected no read pending");
         end
         if (q_w.size() != 0) chk(t_w.pop_front(), 32'(rd_data_w), 32'(q_w.pop_front()));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input int ch, input logic [63:0] d, input logic [7:0] k,
                       input logic l, input logic e);
      mon_tdata[ch*DW +: DW] = d;
      mon_tkeep[ch*KW +: KW] = k;
      mon_tvalid[ch] = 1'b1;
      mon_tready[ch] = 1'b1;
      mon_tlast[ch]  = l;
      mon_terr[ch]   = e;
      tick();
      mon_tvalid[ch] = 1'b0;
      mon_tready[ch] = 1'b0;
      mon_tlast[ch]  = 1'b0;
      mon_terr[ch]   = 1'b0;
   endtask

   // n-beat frame; full keep except the last beat, terr only on the last beat.
   task automatic frame(input int ch, input int n, input logic bc, input logic [7:0] lk,
                        input logic e);
      for (int i = 0; i < n; i++)
         beat(ch, (i == 0 && bc) ? D_BC : D_UC, (i == n-1) ? lk : 8'hFF,
              (i == n-1), e && (i == n-1));
   endtask

   task automatic snap();
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
   endtask

   task automatic push_exp(input string tag, input logic [CW-1:0] es, input logic [CW-1:0] ew);
      q_s.push_back(es);
      t_s.push_back(tag);
      q_w.push_back(ew);
      t_w.push_back({tag, "_w"});
   endtask

   task automatic rd(input int ch, input int sel, input logic [CW-1:0] es,
                     input logic [CW-1:0] ew, input string tag);
      push_exp(tag, es, ew);
      rd_en  = 1'b1;
      rd_ch  = 2'(ch);
      rd_sel = 2'(sel);
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      // Reset state.
      #12;
      chk("rst_rd_data_s", 32'(rd_data_s), 0);
      chk("rst_rd_valid_s", 32'(rd_valid_s), 0);
      chk("rst_ovf_s", 32'(ovf_s), 0);
      chk("rst_rd_data_w", 32'(rd_data_w), 0);
      chk("rst_ovf_w", 32'(ovf_w), 0);
      tick();
      axis_aresetn = 1'b1;
      tick();
      snap();
      rd(0, 0, 0, 0, "rst_pkt0");
      tick();

      // 64-byte frame on ch0.
      frame(0, 8, 1'b0, 8'hFF, 1'b0);
      snap();
      rd(0, 0, 1, 1, "f64_pkt");
      rd(0, 3, 64, 64, "f64_byte");
      rd(0, 1, 0, 0, "f64_err");
      rd(0, 2, 0, 0, "f64_bcast");
      rd(1, 0, 0, 0, "f64_ch1_pkt");
      rd(3, 3, 0, 0, "f64_ch3_byte");
      tick();

      // ch2: broadcast, errored unicast, single-beat broadcast with keep 3F.
      frame(2, 2, 1'b1, 8'hFF, 1'b0);
      frame(2, 3, 1'b0, 8'hFF, 1'b1);
      frame(2, 1, 1'b1, 8'h3F, 1'b0);
      snap();
      rd(2, 0, 3, 3, "ch2_pkt");
      rd(2, 1, 1, 1, "ch2_err");
      rd(2, 2, 2, 2, "ch2_bcast");
      rd(2, 3, 46, 46, "ch2_byte");
      tick();

      // ch1: stalled single-beat frame, keep 0F; only the handshake counts.
      mon_tdata[1*DW +: DW] = D_UC;
      mon_tkeep[1*KW +: KW] = 8'h0F;
      mon_tlast[1] = 1'b1;
      mon_tvalid[1] = 1'b1; tick();
      mon_tvalid[1] = 1'b0; tick();
      mon_tvalid[1] = 1'b1; tick();
      mon_tready[1] = 1'b1; tick();
      mon_tvalid[1] = 1'b0; mon_tready[1] = 1'b0; mon_tlast[1] = 1'b0;
      snap();
      rd(1, 0, 1, 1, "stall_pkt");
      rd(1, 3, 4, 4, "stall_byte");
      tick();

      // ch1: clear coinciding with a tlast beat drops that beat.
      cnt_clr[1] = 1'b1;
      beat(1, D_UC, 8'hFF, 1'b1, 1'b0);
      cnt_clr[1] = 1'b0;
      snap();
      rd(1, 0, 0, 0, "clr_pkt");
      rd(1, 3, 0, 0, "clr_byte");
      frame(1, 2, 1'b0, 8'hFF, 1'b0);
      snap();
      rd(1, 0, 1, 1, "post_clr_pkt");
      rd(1, 3, 16, 16, "post_clr_byte");
      chk("post_clr_ovf_s", 32'(ovf_s), 0);
      tick();

      // Snapshot and read in the same cycle return the old snapshot.
      frame(1, 1, 1'b0, 8'hFF, 1'b0);
      push_exp("snaprd_old", 1, 1);
      rd_en = 1'b1; rd_ch = 2'd1; rd_sel = 2'd0; snap_req = 1'b1;
      tick();
      rd_en = 1'b0; snap_req = 1'b0;
      rd(1, 0, 2, 2, "snaprd_new");
      tick();

      // Snapshot in the same cycle as a beat excludes it.
      snap_req = 1'b1;
      beat(0, D_UC, 8'hFF, 1'b1, 1'b0);
      snap_req = 1'b0;
      rd(0, 0, 1, 1, "snap_excl");
      snap();
      rd(0, 0, 2, 2, "snap_incl_pkt");
      rd(0, 3, 72, 72, "snap_incl_byte");
      tick();

      // ch3 byte overflow: 8191 full beats + 4 bytes = 16'hFFFC, then 8 more.
      mon_tdata[3*DW +: DW] = D_UC;
      mon_tkeep[3*KW +: KW] = 8'hFF;
      mon_tvalid[3] = 1'b1;
      mon_tready[3] = 1'b1;
      repeat (8191) tick();
      mon_tkeep[3*KW +: KW] = 8'h0F;
      tick();
      mon_tvalid[3] = 1'b0;
      mon_tready[3] = 1'b0;
      chk("pre_ovf_s", 32'(ovf_s), 0);
      chk("pre_ovf_w", 32'(ovf_w), 0);
      snap();
      rd(3, 3, 16'hFFFC, 16'hFFFC, "pre_ovf_byte");
      beat(3, D_UC, 8'hFF, 1'b1, 1'b0);
      chk("ovf_s", 32'(ovf_s), 32'h8);
      chk("ovf_w", 32'(ovf_w), 32'h8);
      snap();
      rd(3, 3, 16'hFFFF, 16'h0004, "ovf_byte");
      rd(3, 0, 1, 1, "ovf_pkt");
      tick();
      cnt_clr[3] = 1'b1;
      tick();
      cnt_clr[3] = 1'b0;
      chk("clr_ovf_s", 32'(ovf_s), 0);
      chk("clr_ovf_w", 32'(ovf_w), 0);

      // Reset mid-frame: outputs clear immediately, next beat starts a new frame.
      rd(3, 0, 1, 1, "pre_rst_rd");
      tick();
      beat(0, D_UC, 8'hFF, 1'b0, 1'b0);
      #2;
      axis_aresetn = 1'b0;
      #1;
      chk("midrst_rd_data_s", 32'(rd_data_s), 0);
      chk("midrst_rd_valid_s", 32'(rd_valid_s), 0);
      chk("midrst_ovf_s", 32'(ovf_s), 0);
      chk("midrst_rd_data_w", 32'(rd_data_w), 0);
      tick();
      tick();
      axis_aresetn = 1'b1;
      tick();
      beat(0, D_BC, 8'hFF, 1'b1, 1'b0);
      snap();
      rd(0, 0, 1, 1, "rst_new_pkt");
      rd(0, 2, 1, 1, "rst_new_bcast");
      rd(0, 3, 8, 8, "rst_new_byte");
      rd(2, 0, 0, 0, "rst_ch2_pkt");

      repeat (3) tick();
      chk("drain_s", 32'(q_s.size()), 0);
      chk("drain_w", 32'(q_w.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/eth_port_stats.md
# eth_port_stats

Multi-channel AXI-Stream packet statistics engine for the 10G MAC ports. It passively taps up to NUM_CH accepted streams, such as MAC RX/TX user-side FIFO interfaces, and keeps four counters per channel: packets, error packets, broadcast packets and bytes. Counters are frozen into a snapshot bank on request, so software reads a coherent set. This block replaces the fixed per-port 32-bit counter set. It adds a parametrised channel count, counter width and data width, a byte count, saturate/wrap mode, per-channel clear and sticky overflow flags.

## Interface
Parameters:
- NUM_CH, 4: number of monitored streams (1..16).
- DATA_W, 64: tdata width per channel, a multiple of 64. KEEP_W = DATA_W/8.
- CNT_W, 32: width of every counter (16..48).
- SATURATE, 1: 1 = counters hold at all-ones; 0 = counters wrap to 0.

Ports:
- axis_aclk  in  1  single clock for all logic.
- axis_aresetn  in  1  asynchronous active-low reset.
- mon_tdata  in  NUM_CH*DATA_W  tapped tdata; channel c occupies slice [c*DATA_W +: DATA_W].
- mon_tkeep  in  NUM_CH*KEEP_W  tapped tkeep, contiguous from bit 0.
- mon_tvalid  in  NUM_CH  tapped tvalid.
- mon_tready  in  NUM_CH  tapped tready.
- mon_tlast  in  NUM_CH  tapped tlast.
- mon_terr  in  NUM_CH  frame-bad flag, sampled only on the tlast beat.
- cnt_clr  in  NUM_CH  per-channel synchronous clear pulse.
- snap_req  in  1  copies all live counters into the snapshot bank.
- rd_en  in  1  read strobe.
- rd_ch  in  max(1,$clog2(NUM_CH))  channel to read.
- rd_sel  in  2  counter select: 0 pkt, 1 err, 2 bcast, 3 byte.
- rd_data  out  CNT_W  snapshot value.
- rd_valid  out  1  rd_data qualifier.
- ovf  out  NUM_CH  sticky overflow flag, one per channel.

## Operation
- A beat on channel c is accepted when mon_tvalid[c] and mon_tready[c] are both 1. The block has no backpressure and never drives the stream.
- Per-channel frame tracker, two states:
  - SOP (reset state): an accepted beat with tlast=0 moves to MID. An accepted beat with tlast=1 stays in SOP (single-beat frame).
  - MID: an accepted beat with tlast=1 returns to SOP.
- Broadcast: evaluated on the SOP beat only. The frame is broadcast if tdata[47:0] is 48'hFFFF_FFFF_FFFF and tkeep[5:0] is 6'h3F. The result is held in a per-channel bcast flag until tlast.
- On an accepted tlast beat:
  - pkt increments by 1.
  - err increments by 1 if mon_terr[c]=1.
  - bcast increments by 1 if the bcast flag (or a same-beat SOP match) is set.
- On every accepted beat, byte increments by popcount(tkeep), range 0..KEEP_W.
- Arithmetic is CNT_W+1 bits wide. On carry out:
  - SATURATE=1: the counter takes all-ones.
  - SATURATE=0: the counter takes the wrapped low CNT_W bits.
  - In both modes ovf[c] is set.
- cnt_clr[c] zeroes all four live counters of channel c and clears ovf[c]. Clear wins over a same-cycle increment, and that event is lost. The frame tracker and bcast flag are not affected by cnt_clr.
- snap_req copies all NUM_CH×4 live counters (their pre-update values in that cycle) into the snapshot bank. The snapshot holds until the next snap_req. It is not affected by cnt_clr.
- Reads always return the snapshot bank. If rd_ch ≥ NUM_CH, rd_data is 0.

## Timing
- Reset: all live counters, the snapshot bank, ovf, rd_data and rd_valid are 0. All trackers are in SOP and all bcast flags are 0. Reset takes effect immediately on assertion; release is synchronous to axis_aclk.
- Count latency: a beat accepted in cycle N is visible in the live counters in N+1. ovf updates in N+1.
- Snapshot: with snap_req in N+1, the beat from N is included. With snap_req in N, it is excluded.
- Read latency: rd_en in cycle N gives rd_data/rd_valid in N+1. rd_valid is a one-cycle pulse per rd_en, and reads can be issued back-to-back. rd_data holds its last value when rd_valid=0.
- snap_req and rd_en in the same cycle: the read returns the old snapshot.
- Reset mid-frame: the tracker returns to SOP, and the remainder of the interrupted frame is treated as a new frame.
- Throughput: one beat per cycle per channel, all channels concurrent.

## Test plan
- 64-byte frame (8 beats, last tkeep 8'hFF) on ch0, then snap, then read sel 0 and sel 3 -> pkt=1, byte=64. The ch1..3 counters read 0.
- Broadcast frame (first beat tdata[47:0]=FFFF_FFFF_FFFF) plus a unicast frame on ch2, with mon_terr=1 on the unicast tlast -> pkt=2, bcast=1, err=1.
- Single-beat frame with tkeep=8'h0F and tvalid toggling with tready=0 -> byte=4 after the handshake only; stalled cycles are not counted.
- CNT_W=16, SATURATE=1: preload byte near 16'hFFFC, then a beat with 8 bytes -> byte=16'hFFFF and ovf=1. With SATURATE=0 -> byte=16'h0004 and ovf=1.
- cnt_clr[1] in the same cycle as a tlast beat on ch1 -> pkt reads 0 after snap. The following frame gives pkt=1, and ovf[1] is 0.
- snap_req and rd_en in the same cycle -> the old value is returned. The next read returns the new value. axis_aresetn asserted mid-frame -> all outputs are 0 immediately.
